// File: rtl/ram_be_sync.sv
// Single-port synchronous RAM with per-byte write enables, a registered read
// with a valid strobe, and a clear sequencer that zeroes every word after reset.
module ram_be_sync #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned ADDR_W = 5,
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wena,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rvalid,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nx;
  logic              busy_nx;
  logic              rvalid_nx;
  logic              clr_en_c;
  logic              wr_en_c;
  logic              rd_en_c;

  logic [DATA_W-1:0] mem [DEPTH];

  // Next-state, clear pointer and access decode; accesses are only decoded in RUN.
  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    busy_nx   = busy;
    rvalid_nx = 1'b0;
    clr_en_c  = 1'b0;
    wr_en_c   = 1'b0;
    rd_en_c   = 1'b0;
    case (state)
      S_CLEAR: begin
        clr_en_c = 1'b1;
        busy_nx  = 1'b1;
        ptr_nx   = ptr + ADDR_W'(1);
        if (ptr == LAST_PTR) begin
          state_nx = S_RUN;
          busy_nx  = 1'b0;
        end
      end
      S_RUN: begin
        busy_nx = 1'b0;
        if (ena) begin
          if (wena) begin
            wr_en_c = |be;
          end else begin
            rd_en_c   = 1'b1;
            rvalid_nx = 1'b1;
          end
        end
      end
      default: begin
        state_nx = S_CLEAR;
        ptr_nx   = '0;
        busy_nx  = 1'b1;
      end
    endcase
  end

  // Control and output registers; reset restarts the clear sweep from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLEAR;
      ptr      <= '0;
      busy     <= 1'b1;
      rvalid   <= 1'b0;
      data_out <= '0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      busy   <= busy_nx;
      rvalid <= rvalid_nx;
      if (rd_en_c) begin
        data_out <= mem[addr];
      end
    end
  end

  // Storage: clear sweep or byte-masked write; nothing lands on a reset edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en_c) begin
        mem[ptr] <= '0;
      end else if (wr_en_c) begin
        for (int k = 0; k < BE_W; k++) begin
          if (be[k]) begin
            mem[addr][8*k +: 8] <= data_in[8*k +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_be_sync.sv
// Self-checking bench for ram_be_sync: default 32x32 instance plus a 64-bit x 256 instance,
// checked against a byte-array reference model.
`timescale 1ns/1ps
module tb_ram_be_sync;

  localparam int unsigned AW      = 5;
  localparam int unsigned DW      = 32;
  localparam int unsigned BW      = 4;
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned AW_B    = 8;
  localparam int unsigned DW_B    = 64;
  localparam int unsigned BW_B    = 8;
  localparam int unsigned DEPTH_B = 256;

  logic clk = 1'b0;
  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  logic          rst, ena, wena, rvalid, busy;
  logic [BW-1:0] be;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in, data_out;

  logic            rst_b, ena_b, wena_b, rvalid_b, busy_b;
  logic [BW_B-1:0] be_b;
  logic [AW_B-1:0] addr_b;
  logic [DW_B-1:0] data_in_b, data_out_b;

  ram_be_sync #(.DATA_W(DW), .ADDR_W(AW)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .wena(wena), .be(be), .addr(addr),
    .data_in(data_in), .data_out(data_out), .rvalid(rvalid), .busy(busy)
  );

  ram_be_sync #(.DATA_W(DW_B), .ADDR_W(AW_B)) dut_b (
    .clk(clk), .rst(rst_b), .ena(ena_b), .wena(wena_b), .be(be_b), .addr(addr_b),
    .data_in(data_in_b), .data_out(data_out_b), .rvalid(rvalid_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: memory as bytes, plus the expected output registers.
  logic [7:0]      ref_a [DEPTH][BW];
  logic [7:0]      ref_b [DEPTH_B][BW_B];
  logic [DW-1:0]   exp_dout_a = '0;
  logic            exp_rv_a   = 1'b0;
  logic [DW_B-1:0] exp_dout_b = '0;
  logic            exp_rv_b   = 1'b0;

  function automatic logic [DW-1:0] word_a(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < BW; k++) w = w | (DW'(ref_a[a][k]) << (8 * k));
    return w;
  endfunction

  function automatic logic [DW_B-1:0] word_b(input logic [AW_B-1:0] a);
    logic [DW_B-1:0] w;
    w = '0;
    for (int k = 0; k < BW_B; k++) w = w | (DW_B'(ref_b[a][k]) << (8 * k));
    return w;
  endfunction

  function automatic void clear_a();
    for (int i = 0; i < DEPTH; i++)
      for (int k = 0; k < BW; k++) ref_a[i][k] = 8'h00;
    exp_dout_a = '0;
    exp_rv_a   = 1'b0;
  endfunction

  function automatic void clear_b();
    for (int i = 0; i < DEPTH_B; i++)
      for (int k = 0; k < BW_B; k++) ref_b[i][k] = 8'h00;
    exp_dout_b = '0;
    exp_rv_b   = 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One RUN-mode access on instance A; the model is updated from the access rules.
  task automatic access_a(input logic e, input logic w, input logic [BW-1:0] m,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    ena = e; wena = w; be = m; addr = a; data_in = d;
    exp_rv_a = e && !w;
    if (e && !w) exp_dout_a = word_a(a);
    if (e && w)
      for (int k = 0; k < BW; k++) if (m[k]) ref_a[a][k] = d[8*k +: 8];
    tick();
  endtask

  task automatic access_b(input logic e, input logic w, input logic [BW_B-1:0] m,
                          input logic [AW_B-1:0] a, input logic [DW_B-1:0] d);
    ena_b = e; wena_b = w; be_b = m; addr_b = a; data_in_b = d;
    exp_rv_b = e && !w;
    if (e && !w) exp_dout_b = word_b(a);
    if (e && w)
      for (int k = 0; k < BW_B; k++) if (m[k]) ref_b[a][k] = d[8*k +: 8];
    tick();
  endtask

  // Counts cycles with busy high (starting from the current sample), bounded.
  task automatic measure_clear_a(output int cnt, output bit rv_seen);
    cnt = 0; rv_seen = 1'b0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      if (busy !== 1'b1) break;
      cnt++;
      if (rvalid !== 1'b0) rv_seen = 1'b1;
      tick();
    end
  endtask

  task automatic measure_clear_b(output int cnt, output bit rv_seen);
    cnt = 0; rv_seen = 1'b0;
    for (int i = 0; i < 4 * DEPTH_B; i++) begin
      if (busy_b !== 1'b1) break;
      cnt++;
      if (rvalid_b !== 1'b0) rv_seen = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    int cnt; bit rv_seen;
    rst = 1'b1; ena = 1'b1; wena = 1'b0; addr = '0;
    tick();
    rst = 1'b0;
    n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", data_out); end
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
    measure_clear_a(cnt, rv_seen);
    n_checks++; if (cnt != DEPTH) begin n_fail++; $display("FAIL reset_busy_len: got %0d expected %0d", cnt, DEPTH); end
    n_checks++; if (rv_seen) begin n_fail++; $display("FAIL reset_rvalid_busy: got 1 expected 0"); end
    clear_a();
  endtask

  task automatic test_clear_sweep();
    int cnt; bit rv_seen;
    for (int i = 0; i < 24; i++)
      access_a(1'b1, 1'b1, BW'($urandom), AW'($urandom), $urandom);
    access_a(1'b1, 1'b0, '0, AW'(1), '0);
    rst = 1'b1; ena = 1'b1; wena = 1'b0; addr = AW'($urandom);
    tick();
    rst = 1'b0;
    measure_clear_a(cnt, rv_seen);
    n_checks++; if (cnt != DEPTH) begin n_fail++; $display("FAIL sweep_busy_len: got %0d expected %0d", cnt, DEPTH); end
    n_checks++; if (rv_seen) begin n_fail++; $display("FAIL sweep_rvalid_busy: got 1 expected 0"); end
    clear_a();
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL sweep_exit_rvalid: got %b expected 0", rvalid); end
    for (int i = 0; i < DEPTH; i++) begin
      access_a(1'b1, 1'b0, '0, AW'(i), '0);
      n_checks++; if (rvalid !== 1'b1 || data_out !== exp_dout_a) begin
        n_fail++; $display("FAIL sweep_zero[%0d]: got %h/%b expected %h/1", i, data_out, rvalid, exp_dout_a);
      end
    end
  endtask

  task automatic test_full_word();
    access_a(1'b1, 1'b1, 4'hF, AW'(5), 32'hDEADBEEF);
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL full_write_rvalid: got %b expected 0", rvalid); end
    access_a(1'b1, 1'b0, '0, AW'(5), '0);
    n_checks++; if (data_out !== 32'hDEADBEEF || rvalid !== 1'b1) begin
      n_fail++; $display("FAIL full_read: got %h/%b expected deadbeef/1", data_out, rvalid);
    end
  endtask

  task automatic test_byte_enables();
    access_a(1'b1, 1'b1, 4'hF, AW'(7), 32'h11223344);
    access_a(1'b1, 1'b1, 4'b0101, AW'(7), 32'hAABBCCDD);
    access_a(1'b1, 1'b0, 4'hF, AW'(7), '0);
    n_checks++; if (data_out !== 32'h11BB33DD || rvalid !== 1'b1) begin
      n_fail++; $display("FAIL byte_en: got %h/%b expected 11bb33dd/1", data_out, rvalid);
    end
    access_a(1'b1, 1'b1, 4'h0, AW'(7), 32'hFFFFFFFF);
    access_a(1'b1, 1'b0, '0, AW'(7), '0);
    n_checks++; if (data_out !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL byte_en_none: got %h expected 11bb33dd", data_out);
    end
  endtask

  task automatic test_hold_idle();
    access_a(1'b1, 1'b0, '0, AW'(5), '0);
    n_checks++; if (data_out !== 32'hDEADBEEF || rvalid !== 1'b1) begin
      n_fail++; $display("FAIL hold_read: got %h/%b expected deadbeef/1", data_out, rvalid);
    end
    for (int i = 0; i < 3; i++) begin
      access_a(1'b0, 1'b0, '0, AW'($urandom), $urandom);
      n_checks++; if (data_out !== 32'hDEADBEEF || rvalid !== 1'b0) begin
        n_fail++; $display("FAIL hold_idle[%0d]: got %h/%b expected deadbeef/0", i, data_out, rvalid);
      end
    end
    access_a(1'b1, 1'b1, 4'hF, AW'(5), 32'h0);
    n_checks++; if (data_out !== 32'hDEADBEEF || rvalid !== 1'b0) begin
      n_fail++; $display("FAIL hold_write: got %h/%b expected deadbeef/0", data_out, rvalid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) access_a(1'b1, 1'b1, 4'hF, AW'(10 + i), 32'hA0B0C000 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      access_a(1'b1, 1'b0, '0, AW'(10 + i), '0);
      n_checks++; if (data_out !== 32'hA0B0C000 + 32'(i) || rvalid !== 1'b1) begin
        n_fail++; $display("FAIL b2b[%0d]: got %h/%b expected %h/1", i, data_out, rvalid, 32'hA0B0C000 + 32'(i));
      end
    end
    access_a(1'b1, 1'b1, 4'hF, AW'(11), 32'h5555AAAA);
    access_a(1'b1, 1'b0, '0, AW'(11), '0);
    n_checks++; if (data_out !== 32'h5555AAAA) begin
      n_fail++; $display("FAIL write_then_read: got %h expected 5555aaaa", data_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      access_a($urandom_range(0, 3) != 0, 1'($urandom), BW'($urandom), AW'($urandom), $urandom);
      n_checks++; if (data_out !== exp_dout_a || rvalid !== exp_rv_a) begin
        n_fail++; $display("FAIL random[%0d]: got %h/%b expected %h/%b", i, data_out, rvalid, exp_dout_a, exp_rv_a);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cnt; bit rv_seen;
    rst = 1'b1; ena = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_c10: got %b expected 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    measure_clear_a(cnt, rv_seen);
    n_checks++; if (cnt != DEPTH) begin n_fail++; $display("FAIL mid_restart_len: got %0d expected %0d", cnt, DEPTH); end
    clear_a();
    access_a(1'b1, 1'b1, 4'hF, AW'(3), 32'hCAFEF00D);
    access_a(1'b1, 1'b0, '0, AW'(3), '0);
    n_checks++; if (data_out !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mid_pre: got %h expected cafef00d", data_out); end
    rst = 1'b1; ena = 1'b1; wena = 1'b1; be = 4'hF; addr = AW'(3); data_in = 32'h12345678;
    tick();
    rst = 1'b0; wena = 1'b0;
    n_checks++; if (data_out !== '0 || rvalid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_write: got %h/%b/%b expected 0/0/1", data_out, rvalid, busy);
    end
    measure_clear_a(cnt, rv_seen);
    n_checks++; if (cnt != DEPTH || rv_seen) begin
      n_fail++; $display("FAIL mid_run_len: got %0d/%b expected %0d/0", cnt, rv_seen, DEPTH);
    end
    clear_a();
    access_a(1'b1, 1'b0, '0, AW'(3), '0);
    n_checks++; if (data_out !== 32'h0 || rvalid !== 1'b1) begin
      n_fail++; $display("FAIL mid_addr3: got %h/%b expected 0/1", data_out, rvalid);
    end
  endtask

  task automatic test_param();
    int cnt; bit rv_seen;
    logic [DW_B-1:0] d;
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0; ena_b = 1'b1; wena_b = 1'b0;
    measure_clear_b(cnt, rv_seen);
    n_checks++; if (cnt != DEPTH_B || rv_seen) begin
      n_fail++; $display("FAIL param_clear_len: got %0d/%b expected %0d/0", cnt, rv_seen, DEPTH_B);
    end
    clear_b();
    for (int i = 0; i < DEPTH_B; i++) begin
      d = DW_B'(1) << (i % 64);
      access_b(1'b1, 1'b1, BW_B'($urandom), AW_B'(i), d);
    end
    for (int i = 0; i < DEPTH_B; i++) begin
      access_b(1'b1, 1'b0, '0, AW_B'(i), '0);
      n_checks++; if (data_out_b !== exp_dout_b || rvalid_b !== 1'b1) begin
        n_fail++; $display("FAIL param_walk[%0d]: got %h/%b expected %h/1", i, data_out_b, rvalid_b, exp_dout_b);
      end
    end
    for (int i = 0; i < DEPTH_B; i++) begin
      d = {$urandom, $urandom};
      access_b(1'b1, 1'b1, BW_B'($urandom), AW_B'(i), d);
    end
    for (int i = 0; i < DEPTH_B; i++) begin
      access_b(1'b1, 1'b0, '0, AW_B'(i), '0);
      n_checks++; if (data_out_b !== exp_dout_b || rvalid_b !== 1'b1) begin
        n_fail++; $display("FAIL param_mask[%0d]: got %h/%b expected %h/1", i, data_out_b, rvalid_b, exp_dout_b);
      end
    end
    ena_b = 1'b0;
  endtask

  // Bound on total run time.
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Test sequence.
  initial begin
    rst = 1'b0; ena = 1'b0; wena = 1'b0; be = '0; addr = '0; data_in = '0;
    rst_b = 1'b1; ena_b = 1'b0; wena_b = 1'b0; be_b = '0; addr_b = '0; data_in_b = '0;
    tick();
    test_reset();
    test_clear_sweep();
    test_full_word();
    test_byte_enables();
    test_hold_idle();
    test_back_to_back();
    test_random();
    test_reset_mid();
    ena = 1'b0;
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
